// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg : shared types and port indices for the data-memory arbiter
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_e;

  localparam int PORT_MEM = 0;
  localparam int PORT_LDR = 1;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_rr2.sv
// ----------------------------------------------------------------------------
// dmem_arb_rr2 : two-way round-robin picker, one-hot grant
// Option: DMEM_ARB_FIXED_PRIO_EN turns it into a port-0-first priority encoder
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_arb_rr2 (
  input  logic [1:0] req,
`ifndef DMEM_ARB_FIXED_PRIO_EN
  input  logic       last,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
`else
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // contention: the port that did not win last time goes first
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
`endif
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter : shares the data memory between MEM stage and loader with locks
// Option: DMEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 first)
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [DATA_W-1:0] m0_wd,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rd,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m1_wd,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rd,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd
);

  import dmem_arb_pkg::*;

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [1:0]       pick;
  logic [1:0]       gnt;
  logic             rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rd0_q, rd1_q;

`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic last_q, last_d;
`endif

  dmem_arb_rr2 u_rr2 (
    .req  ({m1_req, m0_req}),
`ifndef DMEM_ARB_FIXED_PRIO_EN
    .last (last_q),
`endif
    .gnt  (pick)
  );

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    gnt     = 2'b00;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        gnt = pick;
        if (gnt[PORT_MEM] && m0_lock) begin
          state_d = ST_LOCK0;
          burst_d = '0;
        end else if (gnt[PORT_LDR] && m1_lock) begin
          state_d = ST_LOCK1;
          burst_d = '0;
        end
      end
      ST_LOCK0: begin
        gnt[PORT_MEM] = m0_req;
        burst_d       = burst_q + CNT_W'(1);
        if ((m0_req && !m0_lock) || (!m0_req && !m0_lock) || (burst_d == C_CNT_LAST)) begin
          state_d = ST_IDLE;
`ifndef DMEM_ARB_FIXED_PRIO_EN
          last_d  = 1'b0;
`endif
        end
      end
      ST_LOCK1: begin
        gnt[PORT_LDR] = m1_req;
        burst_d       = burst_q + CNT_W'(1);
        if ((m1_req && !m1_lock) || (!m1_req && !m1_lock) || (burst_d == C_CNT_LAST)) begin
          state_d = ST_IDLE;
`ifndef DMEM_ARB_FIXED_PRIO_EN
          last_d  = 1'b1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // nothing is granted while reset is held, whatever the state register shows
    if (!reset) begin
      gnt = 2'b00;
    end
`ifndef DMEM_ARB_FIXED_PRIO_EN
    if (gnt[PORT_MEM]) begin
      last_d = 1'b0;
    end else if (gnt[PORT_LDR]) begin
      last_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      burst_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rd0_q     <= '0;
      rd1_q     <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      rvalid0_q <= gnt[PORT_MEM] & ~m0_we;
      rvalid1_q <= gnt[PORT_LDR] & ~m1_we;
      if (gnt[PORT_MEM] && !m0_we) begin
        rd0_q <= mem_rd;
      end
      if (gnt[PORT_LDR] && !m1_we) begin
        rd1_q <= mem_rd;
      end
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  assign m0_gnt    = gnt[PORT_MEM];
  assign m1_gnt    = gnt[PORT_LDR];
  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rd     = rd0_q;
  assign m1_rd     = rd1_q;

  // port 0 payload is parked on the bus when nobody is granted
  assign mem_adr = gnt[PORT_LDR] ? m1_adr : m0_adr;
  assign mem_wd  = gnt[PORT_LDR] ? m1_wd  : m0_wd;
  assign mem_we  = ((gnt[PORT_MEM] & m0_we) | (gnt[PORT_LDR] & m1_we)) & reset;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter : directed scenarios plus randomized traffic vs. a tenure model
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req[2];
  logic        we[2];
  logic        lock[2];
  logic [31:0] adr[2];
  logic [31:0] wd[2];
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;
  logic [31:0] m0_rd, m1_rd, mem_adr, mem_wd, mem_rd;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] phys[64];
  bit          mem_ready = 1'b0;

  int          m_owner;
  int          m_tenure;
  logic        m_last;
  logic        m_rv[2];
  logic [31:0] m_rd[2];
  logic [31:0] ref_mem[16];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_we(we[0]), .m0_lock(lock[0]), .m0_adr(adr[0]), .m0_wd(wd[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rd(m0_rd),
    .m1_req(req[1]), .m1_we(we[1]), .m1_lock(lock[1]), .m1_adr(adr[1]), .m1_wd(wd[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rd(m1_rd),
    .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {16'hC0DE, b, b ^ 8'h5A};
  endfunction

  // data memory: combinational read, write on the rising edge
  assign mem_rd = phys[mem_adr[7:2]];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) phys[i] <= init_word(i);
    end else if (mem_we) begin
      phys[mem_adr[7:2]] <= mem_wd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic l,
                          input logic [31:0] a, input logic [31:0] d);
    req[p]  = r;
    we[p]   = w;
    lock[p] = l;
    adr[p]  = a;
    wd[p]   = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_port(0, 1, 1, 0, 32'h04, 32'h1111_1111);
    set_port(1, 1, 1, 0, 32'h08, 32'h2222_2222);
    for (int c = 0; c < 3; c++) begin
      #3;
      vectors++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin miscompares++; $display("FAIL reset_gnt cyc %0d: got %b%b expected 00", c, m1_gnt, m0_gnt); end
      vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we cyc %0d: got %b expected 0", c, mem_we); end
      tick();
      vectors++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid cyc %0d: got %b%b expected 00", c, m1_rvalid, m0_rvalid); end
      vectors++; if (m0_rd !== 32'h0 || m1_rd !== 32'h0) begin miscompares++; $display("FAIL reset_rd cyc %0d: got %h %h expected 0 0", c, m0_rd, m1_rd); end
    end
  endtask

  task automatic test_round_robin();
    logic e0;
    reset = 1'b1;
    set_port(0, 1, 0, 0, 32'h10, 32'h0);
    set_port(1, 1, 0, 0, 32'h20, 32'h0);
    for (int c = 0; c < 4; c++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      e0 = 1'b1;
`else
      e0 = (c % 2 == 0);
`endif
      #3;
      vectors++; if (m0_gnt !== e0 || m1_gnt !== !e0) begin miscompares++; $display("FAIL rr_gnt cyc %0d: got %b%b expected %b%b", c, m1_gnt, m0_gnt, !e0, e0); end
      tick();
      vectors++; if (m0_rvalid !== e0 || m1_rvalid !== !e0) begin miscompares++; $display("FAIL rr_rvalid cyc %0d: got %b%b expected %b%b", c, m1_rvalid, m0_rvalid, !e0, e0); end
      if (e0) begin
        vectors++; if (m0_rd !== init_word(4)) begin miscompares++; $display("FAIL rr_rd0 cyc %0d: got %h expected %h", c, m0_rd, init_word(4)); end
      end else begin
        vectors++; if (m1_rd !== init_word(8)) begin miscompares++; $display("FAIL rr_rd1 cyc %0d: got %h expected %h", c, m1_rd, init_word(8)); end
      end
    end
    tick();
    req[0] = 1'b0;
    tick();
    req[1] = 1'b0;
  endtask

  task automatic test_write_read();
    set_port(0, 1, 1, 0, 32'h40, 32'hDEAD_BEEF);
    #3;
    vectors++; if (m0_gnt !== 1'b1 || mem_we !== 1'b1) begin miscompares++; $display("FAIL wr_grant: got gnt=%b we=%b expected 1 1", m0_gnt, mem_we); end
    vectors++; if (mem_adr !== 32'h40 || mem_wd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wr_bus: got %h %h expected 00000040 deadbeef", mem_adr, mem_wd); end
    tick();
    vectors++; if (m0_rvalid !== 1'b0) begin miscompares++; $display("FAIL wr_rvalid: got %b expected 0", m0_rvalid); end
    set_port(0, 1, 0, 0, 32'h40, 32'h0);
    #3;
    vectors++; if (m0_gnt !== 1'b1 || mem_we !== 1'b0) begin miscompares++; $display("FAIL rd_grant: got gnt=%b we=%b expected 1 0", m0_gnt, mem_we); end
    tick();
    req[0] = 1'b0;
    vectors++; if (m0_rvalid !== 1'b1 || m0_rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wr_then_rd: got v=%b %h expected 1 deadbeef", m0_rvalid, m0_rd); end
  endtask

  task automatic test_lock_burst();
    for (int b = 1; b <= 4; b++) begin
      set_port(1, 1, 1, 1, 32'h80 + 32'(4 * (b - 1)), 32'h1B00_0000 | 32'(b));
      if (b == 2) set_port(0, 1, 0, 0, 32'h84, 32'h0);
      #3;
      vectors++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || mem_we !== 1'b1) begin miscompares++; $display("FAIL lock_beat %0d: got g1=%b g0=%b we=%b expected 1 0 1", b, m1_gnt, m0_gnt, mem_we); end
      tick();
    end
    set_port(1, 0, 0, 0, 32'h0, 32'h0);
    #3;
    vectors++; if (m0_gnt !== 1'b0) begin miscompares++; $display("FAIL lock_drop_cycle: got g0=%b expected 0", m0_gnt); end
    tick();
    #3;
    vectors++; if (m0_gnt !== 1'b1) begin miscompares++; $display("FAIL lock_after_release: got g0=%b expected 1", m0_gnt); end
    tick();
    req[0] = 1'b0;
    vectors++; if (m0_rvalid !== 1'b1 || m0_rd !== 32'h1B00_0002) begin miscompares++; $display("FAIL lock_readback: got v=%b %h expected 1 1b000002", m0_rvalid, m0_rd); end
  endtask

  task automatic test_forced_release();
    int  n1;
    bit  seen;
    n1   = 0;
    seen = 1'b0;
    set_port(1, 1, 1, 1, 32'h90, 32'h5EED_0000);
    for (int c = 0; c < 20 && !seen; c++) begin
      if (c == 1) set_port(0, 1, 0, 0, 32'h14, 32'h0);
      #3;
      if (m1_gnt === 1'b1) n1++;
      if (m0_gnt === 1'b1) begin
        seen = 1'b1;
        vectors++; if (m1_gnt !== 1'b0) begin miscompares++; $display("FAIL forced_both: got g1=%b expected 0", m1_gnt); end
      end
      tick();
    end
    req[0] = 1'b0;
    vectors++; if (!seen) begin miscompares++; $display("FAIL forced_timeout: got no port-0 grant expected one within 20 cycles"); end
    vectors++; if (n1 != MAX_BURST) begin miscompares++; $display("FAIL forced_count: got %0d port-1 grants expected %0d", n1, MAX_BURST); end
    tick();
    set_port(1, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid_burst();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_port(1, 1, 1, 1, 32'hA0, 32'h0BAD_0001);
    tick();
    set_port(1, 1, 0, 1, 32'hA0, 32'h0);
    tick();
    vectors++; if (m1_rvalid !== 1'b1 || m1_rd !== 32'h0BAD_0001) begin miscompares++; $display("FAIL midrst_beat2: got v=%b %h expected 1 0bad0001", m1_rvalid, m1_rd); end
    reset = 1'b0;
    set_port(1, 1, 1, 1, 32'hA4, 32'h0BAD_0003);
    #3;
    vectors++; if (m1_gnt !== 1'b0 || mem_we !== 1'b0) begin miscompares++; $display("FAIL midrst_beat3: got g1=%b we=%b expected 0 0", m1_gnt, mem_we); end
    tick();
    vectors++; if (m1_rvalid !== 1'b0 || m1_rd !== 32'h0) begin miscompares++; $display("FAIL midrst_regs: got v=%b %h expected 0 0", m1_rvalid, m1_rd); end
    reset = 1'b1;
    set_port(0, 1, 0, 0, 32'h10, 32'h0);
    set_port(1, 1, 1, 0, 32'hA8, 32'h0BAD_0004);
    #3;
    vectors++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin miscompares++; $display("FAIL midrst_first: got g0=%b g1=%b expected 1 0", m0_gnt, m1_gnt); end
    tick();
    req[0] = 1'b0;
    #3;
    vectors++; if (m1_gnt !== 1'b1) begin miscompares++; $display("FAIL midrst_second: got g1=%b expected 1", m1_gnt); end
    tick();
    req[1] = 1'b0;
  endtask

  // reference: ownership measured as tenure in cycles, entry beat included
  task automatic test_random(input int n);
    logic        eg[2];
    logic        exp_we;
    logic [31:0] exp_adr, exp_wd;
    int          x;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    reset = 1'b0;
    set_port(0, 0, 0, 0, 32'h0, 32'h0);
    set_port(1, 0, 0, 0, 32'h0, 32'h0);
    tick();
    m_owner = -1; m_tenure = 0; m_last = 1'b1;
    m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = 32'h0; m_rd[1] = 32'h0;
    eg[0] = 1'b0; eg[1] = 1'b0;
    for (int c = 0; c < n; c++) begin
      reset = ($urandom_range(0, 63) != 0);
      for (int p = 0; p < 2; p++) begin
        if (!(req[p] && !eg[p])) begin
          req[p]  = ($urandom_range(0, 3) != 0);
          we[p]   = 1'($urandom_range(0, 1));
          lock[p] = 1'($urandom_range(0, 1));
          adr[p]  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
          wd[p]   = $urandom;
        end
      end
      #3;
      eg[0] = 1'b0; eg[1] = 1'b0;
      if (reset) begin
        if (m_owner >= 0) begin
          eg[m_owner] = req[m_owner];
        end else if (req[0] && req[1]) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
          eg[0] = 1'b1;
`else
          if (m_last) eg[0] = 1'b1; else eg[1] = 1'b1;
`endif
        end else begin
          eg[0] = req[0];
          eg[1] = req[1];
        end
      end
      exp_we  = (eg[0] && we[0]) || (eg[1] && we[1]);
      exp_adr = eg[1] ? adr[1] : adr[0];
      exp_wd  = eg[1] ? wd[1] : wd[0];
      vectors++; if (m0_gnt !== eg[0]) begin miscompares++; $display("FAIL rand_gnt0 cyc %0d: got %b expected %b", c, m0_gnt, eg[0]); end
      vectors++; if (m1_gnt !== eg[1]) begin miscompares++; $display("FAIL rand_gnt1 cyc %0d: got %b expected %b", c, m1_gnt, eg[1]); end
      vectors++; if (mem_we !== exp_we) begin miscompares++; $display("FAIL rand_we cyc %0d: got %b expected %b", c, mem_we, exp_we); end
      vectors++; if (mem_adr !== exp_adr || mem_wd !== exp_wd) begin miscompares++; $display("FAIL rand_bus cyc %0d: got %h %h expected %h %h", c, mem_adr, mem_wd, exp_adr, exp_wd); end
      m_rv[0] = 1'b0; m_rv[1] = 1'b0;
      if (!reset) begin
        m_owner = -1; m_tenure = 0; m_last = 1'b1;
        m_rd[0] = 32'h0; m_rd[1] = 32'h0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (eg[p]) begin
            m_last = 1'(p);
            if (we[p]) begin
              ref_mem[adr[p][5:2]] = wd[p];
            end else begin
              m_rv[p] = 1'b1;
              m_rd[p] = ref_mem[adr[p][5:2]];
            end
          end
        end
        if (m_owner < 0) begin
          for (int p = 0; p < 2; p++) begin
            if (eg[p] && lock[p]) begin m_owner = p; m_tenure = 1; end
          end
        end else begin
          x = m_owner;
          if ((eg[x] && !lock[x]) || (!req[x] && !lock[x]) || (m_tenure + 1 >= MAX_BURST)) begin
            m_owner = -1;
            m_last  = 1'(x);
          end else begin
            m_tenure++;
          end
        end
      end
      tick();
      vectors++; if (m0_rvalid !== m_rv[0] || m1_rvalid !== m_rv[1]) begin miscompares++; $display("FAIL rand_rvalid cyc %0d: got %b%b expected %b%b", c, m1_rvalid, m0_rvalid, m_rv[1], m_rv[0]); end
      vectors++; if (m0_rd !== m_rd[0] || m1_rd !== m_rd[1]) begin miscompares++; $display("FAIL rand_rd cyc %0d: got %h %h expected %h %h", c, m0_rd, m1_rd, m_rd[0], m_rd[1]); end
    end
    reset = 1'b1;
    set_port(0, 0, 0, 0, 32'h0, 32'h0);
    set_port(1, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    set_port(0, 0, 0, 0, 32'h0, 32'h0);
    set_port(1, 0, 0, 0, 32'h0, 32'h0);
    tick();
    mem_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_write_read();
    test_lock_burst();
    test_forced_release();
    test_reset_mid_burst();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
